// File: rtl/lsu_load_stage.sv
// lsu_load_stage: load-completion / writeback-select stage (one outstanding load, XLEN 32 or 64).
// Optional feature LSU_LOAD_MISALIGN_EXC_EN: misaligned loads complete at once with out_exc set.
module lsu_load_stage #(
  parameter  int XLEN = 32,
  localparam int AW   = $clog2(XLEN/8)
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic            in_is_load,
  input  logic [1:0]      in_size,
  input  logic            in_unsigned,
  input  logic [AW-1:0]   in_addr_lo,
  input  logic            in_rf_we,
  input  logic [4:0]      in_rf_waddr,
  input  logic [XLEN-1:0] in_ex_result,
  input  logic [XLEN-1:0] in_pc,
  input  logic [31:0]     in_inst,
  input  logic            mem_rvalid,
  input  logic [XLEN-1:0] mem_rdata,
  output logic            out_valid,
  input  logic            out_ready,
  output logic            out_rf_we,
  output logic [4:0]      out_rf_waddr,
  output logic [XLEN-1:0] out_rf_wdata,
  output logic [XLEN-1:0] out_pc,
  output logic [31:0]     out_inst,
  output logic            out_exc,
  output logic            byp_valid,
  output logic            byp_pending,
  output logic [4:0]      byp_waddr,
  output logic [XLEN-1:0] byp_wdata,
  output logic [1:0]      dbg_state_o
);

  // Handshakes: a transfer happens on a rising edge where valid & ready are both high.
  // Once out_valid rises, the whole writeback bundle holds until out_ready (or flush).
  typedef enum logic [1:0] {
    S_EMPTY = 2'd0,
    S_WAIT  = 2'd1,
    S_FULL  = 2'd2,
    S_DRAIN = 2'd3
  } state_e;

  state_e          state_q;
  logic            rf_we_q;
  logic [1:0]      size_q;
  logic            unsigned_q;
  logic [AW-1:0]   addr_lo_q;

  logic            accept;
  logic            in_we_eff;
  logic            in_misalign;
  logic [AW-1:0]   held_off;
  logic [AW+2:0]   shamt;
  logic [XLEN-1:0] shifted;
  logic [XLEN-1:0] load_data;

  function automatic logic [AW-1:0] size_mask(input logic [1:0] size);
    logic [3:0] m;
    m = (4'd1 << size) - 4'd1;
    return m[AW-1:0];
  endfunction

  always_comb begin
    in_ready  = rst_n & ~flush &
                ((state_q == S_EMPTY) | ((state_q == S_FULL) & out_ready));
    accept    = in_valid & in_ready;
    in_we_eff = in_rf_we & (in_rf_waddr != 5'd0);
`ifdef LSU_LOAD_MISALIGN_EXC_EN
    in_misalign = in_is_load & ((in_addr_lo & size_mask(in_size)) != '0);
`else
    in_misalign = 1'b0;
`endif
    // Dropping sub-alignment address bits lets one shift serve every access size.
    held_off = addr_lo_q & ~size_mask(size_q);
    shamt    = {held_off, 3'b000};
    shifted  = mem_rdata >> shamt;
    case (size_q)
      2'd0:    load_data = unsigned_q ? XLEN'(shifted[7:0])  : XLEN'($signed(shifted[7:0]));
      2'd1:    load_data = unsigned_q ? XLEN'(shifted[15:0]) : XLEN'($signed(shifted[15:0]));
      2'd2:    load_data = unsigned_q ? XLEN'(shifted[31:0]) : XLEN'($signed(shifted[31:0]));
      default: load_data = shifted;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= S_EMPTY;
      rf_we_q      <= 1'b0;
      size_q       <= 2'd0;
      unsigned_q   <= 1'b0;
      addr_lo_q    <= '0;
      out_valid    <= 1'b0;
      out_rf_we    <= 1'b0;
      out_rf_waddr <= 5'd0;
      out_rf_wdata <= '0;
      out_pc       <= '0;
      out_inst     <= 32'd0;
      out_exc      <= 1'b0;
      byp_valid    <= 1'b0;
      byp_pending  <= 1'b0;
      byp_waddr    <= 5'd0;
      byp_wdata    <= '0;
    end else if (flush) begin
      out_valid   <= 1'b0;
      out_rf_we   <= 1'b0;
      byp_valid   <= 1'b0;
      byp_pending <= 1'b0;
      // An in-flight load still owes a response; DRAIN swallows it.
      case (state_q)
        S_WAIT:  state_q <= mem_rvalid ? S_EMPTY : S_DRAIN;
        S_DRAIN: if (mem_rvalid) state_q <= S_EMPTY;
        default: state_q <= S_EMPTY;
      endcase
    end else if (accept) begin
      out_rf_waddr <= in_rf_waddr;
      out_pc       <= in_pc;
      out_inst     <= in_inst;
      out_exc      <= in_misalign;
      byp_waddr    <= in_rf_waddr;
      rf_we_q      <= in_we_eff & ~in_misalign;
      size_q       <= in_size;
      unsigned_q   <= in_unsigned;
      addr_lo_q    <= in_addr_lo;
      if (in_is_load && !in_misalign) begin
        state_q      <= S_WAIT;
        out_valid    <= 1'b0;
        out_rf_we    <= 1'b0;
        out_rf_wdata <= '0;
        byp_valid    <= 1'b0;
        byp_pending  <= in_we_eff;
        byp_wdata    <= '0;
      end else begin
        state_q      <= S_FULL;
        out_valid    <= 1'b1;
        out_rf_we    <= in_we_eff & ~in_misalign;
        out_rf_wdata <= in_misalign ? '0 : in_ex_result;
        byp_valid    <= in_we_eff & ~in_misalign;
        byp_pending  <= 1'b0;
        byp_wdata    <= in_misalign ? '0 : in_ex_result;
      end
    end else begin
      case (state_q)
        S_WAIT: if (mem_rvalid) begin
          state_q      <= S_FULL;
          out_valid    <= 1'b1;
          out_rf_we    <= rf_we_q;
          out_rf_wdata <= load_data;
          byp_valid    <= rf_we_q;
          byp_pending  <= 1'b0;
          byp_wdata    <= load_data;
        end
        S_FULL: if (out_ready) begin
          state_q   <= S_EMPTY;
          out_valid <= 1'b0;
          out_rf_we <= 1'b0;
          byp_valid <= 1'b0;
        end
        S_DRAIN: if (mem_rvalid) state_q <= S_EMPTY;
        default: ;
      endcase
    end
  end

  assign dbg_state_o = state_q;

endmodule

// File: tb/tb_lsu_load_stage.sv
// Bench for lsu_load_stage: XLEN=32 and XLEN=64 instances share control stimulus; a scoreboard
// queue per instance holds the expected writeback bundle, checked when WB takes it.
module tb_lsu_load_stage;

  localparam int W = 167;
`ifdef LSU_LOAD_MISALIGN_EXC_EN
  localparam bit MIS_EN = 1'b1;
`else
  localparam bit MIS_EN = 1'b0;
`endif

  // clock / reset
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   cyc = 0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  logic        flush = 1'b0, in_valid = 1'b0, in_is_load = 1'b0, in_unsigned = 1'b0, in_rf_we = 1'b0;
  logic [1:0]  in_size = 2'd0;
  logic [2:0]  addr = 3'd0;
  logic [4:0]  waddr = 5'd0;
  logic [63:0] ex = 64'd0, pc = 64'd0, rdata = 64'd0;
  logic [31:0] inst = 32'd0;
  logic        mem_rvalid = 1'b0;
  logic        man_ready = 1'b1, rand_mode = 1'b0, rnd_ready = 1'b1;
  logic        out_ready;
  assign out_ready = rand_mode ? rnd_ready : man_ready;

  logic        in_ready32, out_valid32, out_rf_we32, out_exc32, byp_valid32, byp_pending32;
  logic [4:0]  out_rf_waddr32, byp_waddr32;
  logic [31:0] out_rf_wdata32, out_pc32, out_inst32, byp_wdata32;
  logic [1:0]  dbg32;
  logic        in_ready64, out_valid64, out_rf_we64, out_exc64, byp_valid64, byp_pending64;
  logic [4:0]  out_rf_waddr64, byp_waddr64;
  logic [63:0] out_rf_wdata64, out_pc64, byp_wdata64;
  logic [31:0] out_inst64;
  logic [1:0]  dbg64;

  lsu_load_stage #(.XLEN(32)) u_dut32 (
    .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(in_ready32),
    .in_is_load(in_is_load), .in_size(in_size), .in_unsigned(in_unsigned), .in_addr_lo(addr[1:0]),
    .in_rf_we(in_rf_we), .in_rf_waddr(waddr), .in_ex_result(ex[31:0]), .in_pc(pc[31:0]),
    .in_inst(inst), .mem_rvalid(mem_rvalid), .mem_rdata(rdata[31:0]), .out_valid(out_valid32),
    .out_ready(out_ready), .out_rf_we(out_rf_we32), .out_rf_waddr(out_rf_waddr32),
    .out_rf_wdata(out_rf_wdata32), .out_pc(out_pc32), .out_inst(out_inst32), .out_exc(out_exc32),
    .byp_valid(byp_valid32), .byp_pending(byp_pending32), .byp_waddr(byp_waddr32),
    .byp_wdata(byp_wdata32), .dbg_state_o(dbg32)
  );

  lsu_load_stage #(.XLEN(64)) u_dut64 (
    .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(in_ready64),
    .in_is_load(in_is_load), .in_size(in_size), .in_unsigned(in_unsigned), .in_addr_lo(addr),
    .in_rf_we(in_rf_we), .in_rf_waddr(waddr), .in_ex_result(ex), .in_pc(pc),
    .in_inst(inst), .mem_rvalid(mem_rvalid), .mem_rdata(rdata), .out_valid(out_valid64),
    .out_ready(out_ready), .out_rf_we(out_rf_we64), .out_rf_waddr(out_rf_waddr64),
    .out_rf_wdata(out_rf_wdata64), .out_pc(out_pc64), .out_inst(out_inst64), .out_exc(out_exc64),
    .byp_valid(byp_valid64), .byp_pending(byp_pending64), .byp_waddr(byp_waddr64),
    .byp_wdata(byp_wdata64), .dbg_state_o(dbg64)
  );

  always @(posedge clk) begin
    #1;
    rnd_ready = ($urandom_range(0, 3) != 0);
  end

  // checking
  int n_checks = 0;
  int n_errors = 0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // reference model
  function automatic logic [2:0] nat_mask(input logic [1:0] sz);
    case (sz)
      2'd0:    return 3'd0;
      2'd1:    return 3'd1;
      2'd2:    return 3'd3;
      default: return 3'd7;
    endcase
  endfunction

  function automatic logic mis_model(input int xlen, input logic [1:0] sz, input logic [2:0] a);
    logic [2:0] m;
    m = nat_mask(sz);
    if (xlen == 32) m = m & 3'b011;
    return MIS_EN && ((a & m) != 3'd0);
  endfunction

  function automatic logic [63:0] model_data(input int xlen, input logic [63:0] rd,
                                             input logic [1:0] sz, input logic uns,
                                             input logic [2:0] a);
    logic [63:0] r, res;
    logic [7:0]  b;
    logic [15:0] h;
    logic [31:0] w;
    logic [2:0]  aa;
    r  = (xlen == 32) ? {32'h0, rd[31:0]} : rd;
    aa = (xlen == 32) ? (a & 3'b011) : a;
    b  = r[8*aa +: 8];
    h  = r[16*aa[2:1] +: 16];
    w  = (xlen == 64) ? r[32*aa[2] +: 32] : r[31:0];
    case (sz)
      2'd0:    res = uns ? {56'h0, b} : {{56{b[7]}}, b};
      2'd1:    res = uns ? {48'h0, h} : {{48{h[15]}}, h};
      2'd2:    res = uns ? {32'h0, w} : {{32{w[31]}}, w};
      default: res = r;
    endcase
    return (xlen == 32) ? {32'h0, res[31:0]} : res;
  endfunction

  function automatic logic [W-1:0] pack(input logic exc, input logic we, input logic [4:0] wa,
                                        input logic [63:0] p, input logic [31:0] i,
                                        input logic [63:0] d);
    return {exc, we, wa, p, i, d};
  endfunction

  // scoreboard
  logic [W-1:0] exp32_q[$];
  logic [W-1:0] exp64_q[$];

  always @(negedge clk) begin : mon32
    logic [W-1:0] e;
    if (rst_n && out_valid32 && out_ready) begin
      if (exp32_q.size() == 0) check_eq("unexp_out32", {63'd0, out_valid32}, 64'd0);
      else begin
        e = exp32_q.pop_front();
        check_eq("wdata32", {32'h0, out_rf_wdata32}, {32'h0, e[31:0]});
        check_eq("we32", {63'd0, out_rf_we32}, {63'd0, e[165]});
        check_eq("waddr32", {59'd0, out_rf_waddr32}, {59'd0, e[164:160]});
        check_eq("pc32", {32'h0, out_pc32}, e[159:96]);
        check_eq("inst32", {32'h0, out_inst32}, {32'h0, e[95:64]});
        check_eq("exc32", {63'd0, out_exc32}, {63'd0, e[166]});
        check_eq("byp_valid32", {63'd0, byp_valid32}, {63'd0, e[165]});
        check_eq("byp_wdata32", {32'h0, byp_wdata32}, {32'h0, e[31:0]});
      end
    end
  end

  always @(negedge clk) begin : mon64
    logic [W-1:0] e;
    if (rst_n && out_valid64 && out_ready) begin
      if (exp64_q.size() == 0) check_eq("unexp_out64", {63'd0, out_valid64}, 64'd0);
      else begin
        e = exp64_q.pop_front();
        check_eq("wdata64", out_rf_wdata64, e[63:0]);
        check_eq("we64", {63'd0, out_rf_we64}, {63'd0, e[165]});
        check_eq("waddr64", {59'd0, out_rf_waddr64}, {59'd0, e[164:160]});
        check_eq("pc64", out_pc64, e[159:96]);
        check_eq("exc64", {63'd0, out_exc64}, {63'd0, e[166]});
        check_eq("byp_valid64", {63'd0, byp_valid64}, {63'd0, e[165]});
        check_eq("byp_waddr64", {59'd0, byp_waddr64}, {59'd0, e[164:160]});
      end
    end
  end

  // driver tasks (called at posedge+1)
  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send(input logic ld, input logic [1:0] sz, input logic uns, input logic [2:0] a,
                      input logic we, input logic [4:0] wa, input logic [63:0] exv,
                      input logic [63:0] p, input logic [31:0] i);
    int   guard;
    logic rdy;
    in_valid = 1'b1; in_is_load = ld; in_size = sz; in_unsigned = uns; addr = a;
    in_rf_we = we; waddr = wa; ex = exv; pc = p; inst = i;
    guard = 0;
    do begin
      #1;
      rdy = in_ready32 & in_ready64;
      @(posedge clk);
      #1;
      guard++;
    end while (!rdy && guard < 200);
    if (!rdy) check_eq("accept_timeout", {63'd0, rdy}, 64'd1);
    in_valid = 1'b0;
  endtask

  task automatic issue(input logic ld, input logic [1:0] sz, input logic uns, input logic [2:0] a,
                       input logic we, input logic [4:0] wa, input logic [63:0] exv,
                       input logic [63:0] rd, input logic push, output logic need_rsp);
    logic [63:0] p, d32, d64;
    logic [31:0] i;
    logic        m32, m64;
    p   = {$urandom, $urandom};
    i   = $urandom;
    m32 = ld & mis_model(32, sz, a);
    m64 = ld & mis_model(64, sz, a);
    d32 = !ld ? exv : (m32 ? 64'd0 : model_data(32, rd, sz, uns, a));
    d64 = !ld ? exv : (m64 ? 64'd0 : model_data(64, rd, sz, uns, a));
    if (push) begin
      exp32_q.push_back(pack(m32, we && wa != 5'd0 && !m32, wa, {32'h0, p[31:0]}, i, d32));
      exp64_q.push_back(pack(m64, we && wa != 5'd0 && !m64, wa, p, i, d64));
    end
    send(ld, sz, uns, a, we, wa, exv, p, i);
    need_rsp = ld && !m64;
  endtask

  task automatic respond(input int dly, input logic [63:0] rd);
    tick(dly);
    mem_rvalid = 1'b1;
    rdata = rd;
    tick(1);
    mem_rvalid = 1'b0;
  endtask

  logic        need;
  logic [63:0] rd_v;
  int          t0;

  initial begin : watchdog
    #400000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    // reset
    tick(3);
    check_eq("rst_in_ready", {63'd0, in_ready32}, 64'd0);
    check_eq("rst_out_valid", {62'd0, out_valid32, out_valid64}, 64'd0);
    check_eq("rst_byp", {60'd0, byp_valid32, byp_pending32, byp_valid64, byp_pending64}, 64'd0);
    check_eq("rst_wdata64", out_rf_wdata64, 64'd0);
    check_eq("rst_state", {60'd0, dbg32, dbg64}, 64'd0);
    rst_n = 1'b1;
    #1;
    check_eq("post_rst_in_ready", {62'd0, in_ready32, in_ready64}, 64'd3);
    tick(1);

    // non-load, then back-to-back throughput
    issue(1'b0, 2'd0, 1'b0, 3'd0, 1'b1, 5'd5, 64'hDEAD_BEEF_1234_5678, 64'd0, 1'b1, need);
    check_eq("nl_valid_next", {62'd0, out_valid32, out_valid64}, 64'd3);
    check_eq("nl_wdata32_now", {32'h0, out_rf_wdata32}, 64'h1234_5678);
    t0 = cyc;
    for (int k = 0; k < 4; k++)
      issue(1'b0, 2'd0, 1'b0, 3'd0, 1'b1, 5'(k + 1), {$urandom, $urandom}, 64'd0, 1'b1, need);
    check_eq("b2b_cycles", 64'(cyc - t0), 64'd4);
    tick(2);

    // LB with slow response, then LBU at minimum latency
    rd_v = 64'h1122_3344_80AA_BBCC;
    issue(1'b1, 2'd0, 1'b0, 3'd3, 1'b1, 5'd7, 64'd0, rd_v, 1'b1, need);
    check_eq("lb_state", {62'd0, dbg32}, 64'd1);
    check_eq("lb_pending", {62'd0, byp_pending32, byp_pending64}, 64'd3);
    check_eq("lb_pend_waddr", {59'd0, byp_waddr32}, 64'd7);
    tick(2);
    check_eq("lb_pending_hold", {62'd0, byp_pending32, out_valid32}, 64'd2);
    respond(1, rd_v);
    check_eq("lb_out_valid", {62'd0, out_valid32, byp_pending32}, 64'd2);
    check_eq("lb_wdata32_now", {32'h0, out_rf_wdata32}, 64'hFFFF_FF80);
    issue(1'b1, 2'd0, 1'b1, 3'd3, 1'b1, 5'd8, 64'd0, rd_v, 1'b1, need);
    check_eq("lbu_wait", {63'd0, out_valid32}, 64'd0);
    respond(0, rd_v);
    check_eq("lbu_latency2", {62'd0, out_valid32, out_valid64}, 64'd3);

    // LW at addr 4 and LD
    rd_v = 64'h8000_0001_1111_2222;
    issue(1'b1, 2'd2, 1'b0, 3'd4, 1'b1, 5'd9, 64'd0, rd_v, 1'b1, need);
    respond(1, rd_v);
    check_eq("lw64_wdata_now", out_rf_wdata64, 64'hFFFF_FFFF_8000_0001);
    issue(1'b1, 2'd3, 1'b0, 3'd0, 1'b1, 5'd10, 64'd0, rd_v, 1'b1, need);
    respond(2, rd_v);
    tick(2);

    // flush while a load is in flight
    issue(1'b1, 2'd2, 1'b0, 3'd0, 1'b1, 5'd11, 64'd0, rd_v, 1'b0, need);
    flush = 1'b1;
    #1;
    check_eq("flush_in_ready", {63'd0, in_ready32}, 64'd0);
    tick(1);
    flush = 1'b0;
    #1;
    check_eq("drain_state", {62'd0, dbg32}, 64'd3);
    check_eq("drain_in_ready", {62'd0, in_ready32, in_ready64}, 64'd0);
    tick(1);
    check_eq("drain_hold", {61'd0, in_ready32, out_valid32, byp_pending32}, 64'd0);
    respond(0, rd_v);
    check_eq("drain_done_state", {60'd0, dbg32, dbg64}, 64'd0);
    check_eq("drain_done_ready", {62'd0, in_ready32, out_valid32}, 64'd2);

    // reset mid-WAIT, late response ignored
    issue(1'b1, 2'd0, 1'b0, 3'd1, 1'b1, 5'd12, 64'd0, rd_v, 1'b0, need);
    rst_n = 1'b0;
    tick(1);
    rst_n = 1'b1;
    check_eq("rst_wait_state", {62'd0, dbg64}, 64'd0);
    respond(0, rd_v);
    check_eq("late_rsp_ignored", {61'd0, dbg32, out_valid32}, 64'd0);

    // FULL held with out_ready low, then waddr=0 op
    man_ready = 1'b0;
    issue(1'b0, 2'd0, 1'b0, 3'd0, 1'b1, 5'd13, 64'hA5A5_A5A5_5A5A_5A5A, 64'd0, 1'b1, need);
    fork
      issue(1'b0, 2'd0, 1'b0, 3'd0, 1'b1, 5'd14, 64'h0BAD_F00D_CAFE_0001, 64'd0, 1'b1, need);
      begin
        repeat (3) begin
          @(negedge clk);
          check_eq("hold_in_ready", {62'd0, in_ready32, out_valid32}, 64'd1);
          check_eq("hold_wdata", {32'h0, out_rf_wdata32}, 64'h5A5A_5A5A);
          check_eq("hold_waddr", {59'd0, out_rf_waddr64}, 64'd13);
        end
        @(posedge clk);
        #1;
        man_ready = 1'b1;
      end
    join
    issue(1'b0, 2'd0, 1'b0, 3'd0, 1'b1, 5'd0, 64'h77, 64'd0, 1'b1, need);
    check_eq("x0_we_byp", {60'd0, out_rf_we32, byp_valid32, out_rf_we64, byp_valid64}, 64'd0);
    tick(2);

    // misaligned LH
    rd_v = 64'h5555_6666_7777_F00D;
    issue(1'b1, 2'd1, 1'b0, 3'd1, 1'b1, 5'd15, 64'd0, rd_v, 1'b1, need);
    if (need) respond(1, rd_v);
    else check_eq("mis_exc_next", {61'd0, out_valid64, out_exc64, out_rf_we64}, 64'd6);
    tick(2);

    // random aligned traffic with random back-pressure
    rand_mode = 1'b1;
    for (int k = 0; k < 40; k++) begin
      logic [1:0] sz;
      logic       ld;
      sz = 2'($urandom_range(0, 3));
      ld = 1'($urandom_range(0, 1));
      rd_v = {$urandom, $urandom};
      issue(ld, sz, 1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)) & ~nat_mask(sz),
            1'($urandom_range(0, 1)), 5'($urandom_range(0, 31)), {$urandom, $urandom},
            rd_v, 1'b1, need);
      if (need) respond($urandom_range(0, 3), rd_v);
    end
    rand_mode = 1'b0;
    for (int g = 0; g < 50 && (exp32_q.size() != 0 || exp64_q.size() != 0); g++) tick(1);
    check_eq("sb_drain32", 64'(exp32_q.size()), 64'd0);
    check_eq("sb_drain64", 64'(exp64_q.size()), 64'd0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/lsu_load_stage.md
# lsu_load_stage

Parametrised load-completion / writeback-select stage of the RISC-V pipeline, between the LSU request stage and WB. Replaces the fixed stall-vector register with a valid/ready handshake, tolerates variable-latency data-memory responses (one outstanding load), extracts and sign/zero-extends byte/half/word/doubleword load data for XLEN 32 or 64, and drives the forwarding bus, including a pending indication for loads still in flight.

## Interface
- XLEN, 32, datapath width; legal values 32, 64. AW = log2(XLEN/8).
- clk  in  1  clock
- rst_n  in  1  reset, synchronous, active-low
- flush  in  1  discard held/in-flight op (redirect)
- in_valid / in_ready  in / out  1  upstream handshake
- in_is_load  in  1  op is a load; otherwise in_ex_result is the writeback value
- in_size  in  2  0 byte, 1 half, 2 word, 3 dword (XLEN=64 only)
- in_unsigned  in  1  zero-extend load data
- in_addr_lo  in  AW  low address bits of the load
- in_rf_we / in_rf_waddr  in  1 / 5  register write enable / address
- in_ex_result, in_pc  in  XLEN  ALU result, PC; in_inst  in  32  instruction
- mem_rvalid / mem_rdata  in  1 / XLEN  memory response, naturally aligned XLEN-wide beat
- out_valid / out_ready  out / in  1  downstream (WB) handshake
- out_rf_we, out_rf_waddr, out_rf_wdata (XLEN), out_pc (XLEN), out_inst (32), out_exc (1)  out  writeback bundle
- byp_valid, byp_pending, byp_waddr (5), byp_wdata (XLEN)  out  forwarding bus

## Operation
- States: EMPTY, WAIT, FULL, DRAIN. in_ready = (EMPTY | (FULL & out_ready)) & !flush.
- EMPTY: accept non-load -> FULL with wdata = in_ex_result; accept load -> WAIT holding control fields.
- WAIT: mem_rvalid -> FULL with wdata = aligned/extended mem_rdata.
- FULL: out_valid=1. out_ready & new accept -> FULL or WAIT (back-to-back); out_ready without accept -> EMPTY; else hold all outputs stable.
- flush (highest priority, in_valid ignored): EMPTY/FULL -> EMPTY; WAIT -> DRAIN, or EMPTY if mem_rvalid same cycle; DRAIN stays DRAIN.
- DRAIN: in_ready=0; mem_rvalid discarded -> EMPTY.
- mem_rvalid in EMPTY/FULL is a protocol error; ignored.
- Extraction: byte = rdata[8*addr_lo +:8]; half = rdata[16*(addr_lo>>1) +:16]; word = rdata[32*(addr_lo>>2) +:32] (XLEN=64), rdata (XLEN=32); dword = rdata. Extend to XLEN by in_unsigned. in_size=3 with XLEN=32 returns rdata unmodified.
- out_rf_we forced 0 when waddr==0 or out_exc=1.
- Bypass: byp_valid = FULL & out_rf_we; byp_pending = WAIT & held rf_we & waddr!=0 (hazard unit must stall consumers); byp_waddr/byp_wdata mirror held fields.

## Timing
- Reset: state EMPTY; every output 0 (in_ready 0 while rst_n low, 1 first cycle after).
- Non-load accepted cycle N -> out_valid at N+1; throughput 1/cycle with out_ready=1.
- Load: response in cycle M (earliest N+1) -> out_valid at M+1; minimum load latency 2.
- All out_* and byp_* registered except in_ready.
- Reset mid-WAIT returns to EMPTY; late response after reset is discarded as EMPTY-state error.

## Configuration
- LSU_LOAD_MISALIGN_EXC_EN defined: load with addr_lo not a multiple of 2^in_size goes directly EMPTY -> FULL with out_exc=1, out_rf_we=0, wdata=0; LSU issues no memory request for it.
- Undefined: address bits below natural alignment are ignored (truncated); out_exc tied 0; every load waits for a response.

## Test plan
- XLEN=32, non-load ex_result=0x1234_5678, waddr=5, out_ready=1 -> out_valid next cycle, wdata 0x12345678; 4 back-to-back ops at 1/cycle.
- XLEN=32, LB addr_lo=3, rdata=0x80AA_BBCC, response 3 cycles late -> byp_pending high during WAIT, wdata 0xFFFF_FF80; LBU -> 0x0000_0080.
- XLEN=64, LW addr_lo=4, rdata=0x8000_0001_1111_2222 -> wdata 0xFFFF_FFFF_8000_0001; LD -> full rdata.
- Load in WAIT, flush, response 2 cycles later -> DRAIN, no out_valid, in_ready 0 until response, then EMPTY.
- FULL with out_ready=0 for 3 cycles, in_valid=1 -> outputs stable, in_ready=0; waddr=0 op -> out_rf_we=0, byp_valid=0.
- With LSU_LOAD_MISALIGN_EXC_EN: LH addr_lo=1 -> out_exc=1, out_rf_we=0 next cycle; without: wdata from rdata[15:0].
